// File: rtl/if_fetch_pkg.sv
// Shared definitions for the RV32I instruction-fetch stage: bus ranges, control
// constants, the JAL opcode, IF FSM encodings and the static next-PC predictor.
package if_fetch_pkg;

  localparam int STALL_W  = 6;
  localparam int ADDR_W   = 32;
  localparam int INST_W   = 32;
  localparam int STALL_IF = 1;

  localparam logic JUMP   = 1'b1;
  localparam logic STALL  = 1'b1;
  localparam logic ENABLE = 1'b1;

  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_FLUSH = 2'd3
  } if_state_e;

  typedef struct packed {
    logic              taken;
    logic [ADDR_W-1:0] target;
  } pred_t;

  // JAL is taken to its J-immediate target; everything else falls through to pc+4.
  function automatic pred_t predict(input logic [ADDR_W-1:0] pc, input logic [INST_W-1:0] inst);
    pred_t             p;
    logic [ADDR_W-1:0] imm;
    imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    if (inst[6:0] == OP_JAL) begin
      p.taken  = 1'b1;
      p.target = pc + imm;
    end else begin
      p.taken  = 1'b0;
      p.target = pc + 32'd4;
    end
    return p;
  endfunction

endpackage

// File: rtl/if_icache.sv
// Direct-mapped instruction cache, one word per line; lookup is combinational,
// fill is synchronous. Only instantiated by if_fetch when ICACHE_EN is defined.
module if_icache
  import if_fetch_pkg::*;
#(
  parameter int IDX_W = 7
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic [29:0]       lookup_addr,
  output logic              hit,
  output logic [INST_W-1:0] hit_inst,
  input  logic              fill_en,
  input  logic [29:0]       fill_addr,
  input  logic [INST_W-1:0] fill_inst
);

  localparam int LINES = 1 << IDX_W;
  localparam int TAG_W = 30 - IDX_W;

  logic [LINES-1:0]  valid_r;
  logic [TAG_W-1:0]  tag_r  [LINES];
  logic [INST_W-1:0] data_r [LINES];

  logic [IDX_W-1:0]  lookup_idx_s;
  logic [IDX_W-1:0]  fill_idx_s;

  assign lookup_idx_s = lookup_addr[IDX_W-1:0];
  assign fill_idx_s   = fill_addr[IDX_W-1:0];

  // Hit detection against the current PC.
  always_comb begin
    hit      = valid_r[lookup_idx_s] && (tag_r[lookup_idx_s] == lookup_addr[29:IDX_W]);
    hit_inst = data_r[lookup_idx_s];
  end

  // Valid bits: cleared only by reset, set on fill.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      valid_r <= '0;
    end else if (fill_en) begin
      valid_r[fill_idx_s] <= 1'b1;
    end
  end

  // Tag and data storage, no reset needed behind the valid bits.
  always_ff @(posedge clk_in) begin
    if (fill_en) begin
      tag_r[fill_idx_s]  <= fill_addr[29:IDX_W];
      data_r[fill_idx_s] <= fill_inst;
    end
  end

endmodule

// File: rtl/if_fetch.sv
// IF stage: owns the PC, fetches one word at a time, predicts statically and
// drives IF/ID. Define ICACHE_EN to add the direct-mapped i-cache (if_icache).
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter int              ICACHE_IDX_W = 7,
  parameter logic [ADDR_W-1:0] RESET_PC   = 32'h0000_0000
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               rdy_in,
  input  logic [STALL_W-1:0] stall_in,
  input  logic               pcJump_in,
  input  logic [ADDR_W-1:0]  pcTarget_in,
  output logic               if_req_out,
  output logic [ADDR_W-1:0]  if_addr_out,
  input  logic               mem_done_in,
  input  logic [INST_W-1:0]  mem_inst_in,
  output logic               instE_out,
  output logic [ADDR_W-1:0]  pc_out,
  output logic [INST_W-1:0]  inst_out,
  output logic               taken_out,
  output logic [ADDR_W-1:0]  pcPred_out
);

  if (ICACHE_IDX_W < 1 || ICACHE_IDX_W > 28) begin : g_bad_idx
    $error("if_fetch: ICACHE_IDX_W out of range");
  end

  if_state_e         state_r;
  logic [ADDR_W-1:0] pc_r;
  logic              stall_s;
  logic              cache_hit_s;
  logic [INST_W-1:0] cache_inst_s;
  logic [INST_W-1:0] word_s;
  pred_t             pred_s;
  logic              unused_s;

  assign stall_s  = (stall_in[STALL_IF] == STALL);
  assign unused_s = ^{stall_in[STALL_W-1:STALL_IF+1], stall_in[STALL_IF-1:0]};

`ifdef ICACHE_EN
  logic fill_en_s;

  // Fill only with a word that is actually presented, never a discarded one.
  always_comb begin
    if (!rst_in && rdy_in && state_r == S_WAIT && mem_done_in && pcJump_in != JUMP) begin
      fill_en_s = 1'b1;
    end else begin
      fill_en_s = 1'b0;
    end
  end

  if_icache #(.IDX_W(ICACHE_IDX_W)) u_icache (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .lookup_addr (pc_r[ADDR_W-1:2]),
    .hit         (cache_hit_s),
    .hit_inst    (cache_inst_s),
    .fill_en     (fill_en_s),
    .fill_addr   (pc_r[ADDR_W-1:2]),
    .fill_inst   (mem_inst_in)
  );
`else
  assign cache_hit_s  = 1'b0;
  assign cache_inst_s = 32'h0000_0000;
`endif

  // Word source for presentation: memory while waiting, cache otherwise.
  always_comb begin
    if (state_r == S_WAIT) begin
      word_s = mem_inst_in;
    end else begin
      word_s = cache_inst_s;
    end
    pred_s = predict(pc_r, word_s);
  end

  // Fetch FSM with all IF/ID and memory-request outputs registered.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      pc_r        <= RESET_PC;
      // A request still outstanding at reset will complete later and must be dropped.
      state_r     <= (if_req_out || state_r == S_FLUSH) ? S_FLUSH : S_IDLE;
      if_req_out  <= 1'b0;
      if_addr_out <= 32'h0000_0000;
      instE_out   <= 1'b0;
      pc_out      <= 32'h0000_0000;
      inst_out    <= 32'h0000_0000;
      taken_out   <= 1'b0;
      pcPred_out  <= 32'h0000_0000;
    end else if (rdy_in) begin
      if (pcJump_in == JUMP) begin
        pc_r      <= pcTarget_in;
        instE_out <= 1'b0;
        case (state_r)
          S_WAIT, S_FLUSH: begin
            if (mem_done_in) begin
              if_req_out <= 1'b0;
              state_r    <= S_IDLE;
            end else begin
              state_r    <= S_FLUSH;
            end
          end
          S_IDLE, S_HOLD: state_r <= S_IDLE;
          default: begin
            if_req_out <= 1'b0;
            state_r    <= S_IDLE;
          end
        endcase
      end else begin
        case (state_r)
          S_IDLE: begin
            if (stall_s) begin
              state_r <= S_IDLE;
            end else if (cache_hit_s) begin
              pc_out     <= pc_r;
              inst_out   <= word_s;
              taken_out  <= pred_s.taken;
              pcPred_out <= pred_s.target;
              pc_r       <= pred_s.target;
              instE_out  <= ENABLE;
            end else begin
              instE_out   <= 1'b0;
              if_req_out  <= 1'b1;
              if_addr_out <= pc_r;
              state_r     <= S_WAIT;
            end
          end
          S_WAIT: begin
            if (mem_done_in) begin
              pc_out     <= pc_r;
              inst_out   <= word_s;
              taken_out  <= pred_s.taken;
              pcPred_out <= pred_s.target;
              pc_r       <= pred_s.target;
              instE_out  <= ENABLE;
              if_req_out <= 1'b0;
              state_r    <= stall_s ? S_HOLD : S_IDLE;
            end else begin
              state_r    <= S_WAIT;
            end
          end
          S_HOLD: begin
            if (stall_s) begin
              state_r   <= S_HOLD;
            end else begin
              instE_out <= 1'b0;
              state_r   <= S_IDLE;
            end
          end
          S_FLUSH: begin
            if (mem_done_in) begin
              if_req_out <= 1'b0;
              state_r    <= S_IDLE;
            end else begin
              state_r    <= S_FLUSH;
            end
          end
          default: begin
            if_req_out <= 1'b0;
            instE_out  <= 1'b0;
            state_r    <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule
